// File: rtl/iv_sweep_pkg.sv
// Shared types and helpers for the gate/source-drain IV sweep sequencer:
// FSM state encoding, default record field widths and the saturating DAC code math.
package iv_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CONVERT,
        EMIT,
        ADVANCE,
        FINISH
    } state_t;

    localparam int DAC_W_DEF = 8;
    localparam int ADC_W_DEF = 12;
    localparam int CNT_W_DEF = 5;
    localparam int REC_W_DEF = 2 * DAC_W_DEF + ADC_W_DEF;

    // Returns {clip, code}. 32 bits is wider than DAC_W+CNT_W+1 for any legal
    // configuration, so the sum can never wrap before the saturation compare.
    function automatic logic [32:0] sat_code(input logic [31:0] base,
                                             input logic [31:0] step,
                                             input logic [31:0] idx,
                                             input int unsigned dac_w);
        logic [31:0] sum;
        logic [31:0] max_code;
        sum      = base + idx * step;
        max_code = (32'd1 << dac_w) - 32'd1;
        if (sum > max_code) begin
            return {1'b1, max_code};
        end
        return {1'b0, sum};
    endfunction

endpackage

// File: rtl/iv_code_gen.sv
// Saturating DAC code generator: code = min(base + idx*step, 2^DAC_W-1), clip flags saturation.
// Purely combinational; the sequencer registers the result in its LOAD state.
module iv_code_gen
    import iv_sweep_pkg::*;
#(
    parameter int DAC_W = DAC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic [DAC_W-1:0] base,
    input  logic [DAC_W-1:0] step,
    input  logic [CNT_W-1:0] idx,
    output logic [DAC_W-1:0] code,
    output logic             clip
);

    logic [32:0] res;

    assign res  = sat_code(32'(base), 32'(step), 32'(idx), DAC_W);
    assign code = res[DAC_W-1:0];
    // Upper code bits are zero whenever clip is clear, so folding them in is free.
    assign clip = res[32] | (|res[31:DAC_W]);

endmodule

// File: rtl/iv_sweep_sequencer.sv
// Two-axis IV sweep: per point load codes, settle SETTLE_CYC clocks, convert, emit one record.
// First adc_start 2+SETTLE_CYC cycles after start; out_ready low holds the record and stalls the sweep.
module iv_sweep_sequencer
    import iv_sweep_pkg::*;
#(
    parameter int DAC_W      = DAC_W_DEF,
    parameter int ADC_W      = ADC_W_DEF,
    parameter int SETTLE_CYC = 64,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [DAC_W-1:0]         vg_start,
    input  logic [DAC_W-1:0]         vg_step,
    input  logic [DAC_W-1:0]         vsd_start,
    input  logic [DAC_W-1:0]         vsd_step,
    input  logic [CNT_W-1:0]         vg_count,
    input  logic [CNT_W-1:0]         vsd_count,
    output logic [DAC_W-1:0]         vg_code,
    output logic [DAC_W-1:0]         vsd_code,
    output logic                     adc_start,
    input  logic                     adc_done,
    input  logic [ADC_W-1:0]         adc_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*DAC_W+ADC_W-1:0] out_data,
    output logic                     busy,
    output logic                     done,
    output logic                     clipped
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    state_t             state;
    logic [DAC_W-1:0]   vg_start_l, vg_step_l, vsd_start_l, vsd_step_l;
    logic [CNT_W-1:0]   vg_count_l, vsd_count_l;
    logic [CNT_W-1:0]   i_idx, j_idx;
    logic [SET_W-1:0]   settle_cnt;
    logic [DAC_W-1:0]   vg_next, vsd_next;
    logic               vg_clip, vsd_clip;

    iv_code_gen #(.DAC_W(DAC_W), .CNT_W(CNT_W)) u_vg_gen (
        .base (vg_start_l),
        .step (vg_step_l),
        .idx  (i_idx),
        .code (vg_next),
        .clip (vg_clip)
    );

    iv_code_gen #(.DAC_W(DAC_W), .CNT_W(CNT_W)) u_vsd_gen (
        .base (vsd_start_l),
        .step (vsd_step_l),
        .idx  (j_idx),
        .code (vsd_next),
        .clip (vsd_clip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            vg_start_l  <= '0;
            vg_step_l   <= '0;
            vsd_start_l <= '0;
            vsd_step_l  <= '0;
            vg_count_l  <= '0;
            vsd_count_l <= '0;
            i_idx       <= '0;
            j_idx       <= '0;
            settle_cnt  <= '0;
            vg_code     <= '0;
            vsd_code    <= '0;
            adc_start   <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            clipped     <= 1'b0;
        end else begin
            adc_start <= 1'b0;
            done      <= 1'b0;
            // FINISH is already on its way out with done pulsing, so abort there is moot.
            if (abort && state != IDLE && state != FINISH) begin
                state     <= FINISH;
                done      <= 1'b1;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            vg_start_l  <= vg_start;
                            vg_step_l   <= vg_step;
                            vsd_start_l <= vsd_start;
                            vsd_step_l  <= vsd_step;
                            vg_count_l  <= vg_count;
                            vsd_count_l <= vsd_count;
                            i_idx       <= '0;
                            j_idx       <= '0;
                            settle_cnt  <= '0;
                            clipped     <= 1'b0;
                            busy        <= 1'b1;
                            state       <= LOAD;
                        end
                    end
                    LOAD: begin
                        vg_code    <= vg_next;
                        vsd_code   <= vsd_next;
                        clipped    <= clipped | vg_clip | vsd_clip;
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                    SETTLE: begin
                        if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                            adc_start <= 1'b1;
                            state     <= CONVERT;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    CONVERT: begin
                        if (adc_done) begin
                            out_data  <= {vg_code, vsd_code, adc_data};
                            out_valid <= 1'b1;
                            state     <= EMIT;
                        end
                    end
                    EMIT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            state     <= ADVANCE;
                        end
                    end
                    ADVANCE: begin
                        if (j_idx == vsd_count_l) begin
                            j_idx <= '0;
                            if (i_idx == vg_count_l) begin
                                done  <= 1'b1;
                                state <= FINISH;
                            end else begin
                                i_idx <= i_idx + 1'b1;
                                state <= LOAD;
                            end
                        end else begin
                            j_idx <= j_idx + 1'b1;
                            state <= LOAD;
                        end
                    end
                    FINISH: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
